// File: rtl/ps2_arrow_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_arrow_decoder_if
//  Purpose  : Byte-stream input and key-level outputs of ps2_arrow_decoder.
//             master = byte source / key consumer, slave = the decoder.
//             Optional macro PS2_DEC_SPACE_EN adds the key_space level.
//  Revision : 1.0  initial release
// ============================================================================
interface ps2_arrow_decoder_if;
  logic [7:0] received_data;
  logic       received_data_en;
  logic       key_up;
  logic       key_down;
  logic       key_left;
  logic       key_right;
`ifdef PS2_DEC_SPACE_EN
  logic       key_space;
`endif
  logic       make_pulse;
  logic       break_pulse;
  logic [7:0] last_code;
  logic       seq_error;

  modport master (
    output received_data, received_data_en,
`ifdef PS2_DEC_SPACE_EN
    input  key_space,
`endif
    input  key_up, key_down, key_left, key_right,
    input  make_pulse, break_pulse, last_code, seq_error
  );

  modport slave (
    input  received_data, received_data_en,
`ifdef PS2_DEC_SPACE_EN
    output key_space,
`endif
    output key_up, key_down, key_left, key_right,
    output make_pulse, break_pulse, last_code, seq_error
  );
endinterface
`default_nettype wire

// File: rtl/ps2_arrow_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_arrow_decoder
//  Purpose  : Parses the PS/2 Set-2 byte stream (E0 extended, F0 break,
//             E1 pause) into held levels for the four arrow keys plus
//             single-cycle make/break/error strobes.
//             Optional macro PS2_DEC_SPACE_EN also tracks unprefixed code 29
//             on key_space.
//  Revision : 1.0  initial release
// ============================================================================
module ps2_arrow_decoder #(
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter bit REQUIRE_E0     = 1'b0
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  ps2_arrow_decoder_if.slave  bus
);

  // Byte values with special meaning in the stream
  localparam logic [7:0] c_E0 = 8'hE0;
  localparam logic [7:0] c_F0 = 8'hF0;
  localparam logic [7:0] c_E1 = 8'hE1;
  localparam logic [7:0] c_AA = 8'hAA;
  localparam logic [7:0] c_FA = 8'hFA;
  localparam logic [7:0] c_FE = 8'hFE;
  localparam logic [7:0] c_OVR_LO = 8'h00;
  localparam logic [7:0] c_OVR_HI = 8'hFF;

  // Tracked key codes; bit order in r_keys: up, down, left, right[, space]
  localparam logic [7:0] c_UP    = 8'h75;
  localparam logic [7:0] c_DOWN  = 8'h72;
  localparam logic [7:0] c_LEFT  = 8'h6B;
  localparam logic [7:0] c_RIGHT = 8'h74;
  localparam logic [7:0] c_SPACE = 8'h29;

`ifdef PS2_DEC_SPACE_EN
  localparam int c_NKEYS = 5;
`else
  localparam int c_NKEYS = 4;
`endif

  // Remaining bytes after E1 in the pause sequence (14 77 E1 F0 14 F0 77)
  localparam logic [2:0] c_SKIP_LEN = 3'd7;

  localparam int c_CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_TERM = c_CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXT     = 3'd1,
    S_BRK     = 3'd2,
    S_EXT_BRK = 3'd3,
    S_SKIP    = 3'd4
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [2:0]           r_skip;
  logic [c_NKEYS-1:0]   r_keys;
  logic                 r_make_pulse;
  logic                 r_break_pulse;
  logic                 r_seq_error;
  logic [7:0]           r_last_code;

  logic [7:0]           w_byte;
  logic                 w_en;
  logic                 w_overrun;
  logic                 w_in_prefix;
  logic                 w_ext;
  logic                 w_brk;
  logic                 w_arrow_ok;
  logic                 w_complete;
  logic                 w_timeout;
  logic [c_NKEYS-1:0]   w_hit;

  assign w_byte      = bus.received_data;
  assign w_en        = bus.received_data_en;
  assign w_overrun   = (w_byte == c_OVR_LO) || (w_byte == c_OVR_HI);
  assign w_ext       = (r_state == S_EXT) || (r_state == S_EXT_BRK);
  assign w_brk       = (r_state == S_BRK) || (r_state == S_EXT_BRK);
  assign w_in_prefix = w_ext || w_brk;
  // A byte arriving on the terminal count takes precedence over the timeout
  assign w_timeout   = !w_en && w_in_prefix && (r_cnt == c_CNT_TERM);

  // Unprefixed arrow codes are numpad keys; optionally reject them
  if (REQUIRE_E0) begin : g_require_e0
    assign w_arrow_ok = w_ext;
  end else begin : g_any_prefix
    assign w_arrow_ok = 1'b1;
  end

  // Decide whether the current byte finishes a make or break sequence
  always_comb begin
    w_complete = 1'b0;
    if (w_en && !w_overrun) begin
      case (r_state)
        S_IDLE:           w_complete = !(w_byte inside {c_E0, c_F0, c_E1, c_AA, c_FA, c_FE});
        S_EXT:            w_complete = !(w_byte inside {c_E0, c_F0});
        S_BRK, S_EXT_BRK: w_complete = !(w_byte inside {c_E0, c_F0, c_E1});
        default:          w_complete = 1'b0;
      endcase
    end
  end

  // One-hot map of the current byte onto the tracked key bits
  always_comb begin
    w_hit = '0;
    if (w_arrow_ok) begin
      case (w_byte)
        c_UP:    w_hit[0] = 1'b1;
        c_DOWN:  w_hit[1] = 1'b1;
        c_LEFT:  w_hit[2] = 1'b1;
        c_RIGHT: w_hit[3] = 1'b1;
        default: ;
      endcase
    end
`ifdef PS2_DEC_SPACE_EN
    if (!w_ext && (w_byte == c_SPACE)) w_hit[4] = 1'b1;
`endif
  end

  // Sequence FSM with prefix timeout, pause skipping and registered outputs
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_skip        <= '0;
      r_keys        <= '0;
      r_make_pulse  <= 1'b0;
      r_break_pulse <= 1'b0;
      r_seq_error   <= 1'b0;
      r_last_code   <= '0;
    end else begin
      r_make_pulse  <= 1'b0;
      r_break_pulse <= 1'b0;
      r_seq_error   <= 1'b0;
      if (w_en) begin
        r_cnt <= '0;
        if (w_overrun) begin
          // Controller lost bytes: levels can no longer be trusted
          r_keys      <= '0;
          r_seq_error <= 1'b1;
          r_skip      <= '0;
          r_state     <= S_IDLE;
        end else if (w_complete) begin
          r_state     <= S_IDLE;
          r_last_code <= w_byte;
          if (w_brk) begin
            r_keys        <= r_keys & ~w_hit;
            r_break_pulse <= |(w_hit & r_keys);
          end else begin
            r_keys       <= r_keys | w_hit;
            r_make_pulse <= |(w_hit & ~r_keys);
          end
        end else begin
          case (r_state)
            S_IDLE: begin
              case (w_byte)
                c_E0: r_state <= S_EXT;
                c_F0: r_state <= S_BRK;
                c_E1: begin
                  r_state <= S_SKIP;
                  r_skip  <= c_SKIP_LEN;
                end
                default: ;
              endcase
            end
            S_EXT: begin
              if (w_byte == c_F0) r_state <= S_EXT_BRK;
            end
            S_SKIP: begin
              if (r_skip <= 3'd1) begin
                r_skip  <= '0;
                r_state <= S_IDLE;
              end else begin
                r_skip <= r_skip - 3'd1;
              end
            end
            // Repeated prefixes inside a break sequence keep waiting
            default: ;
          endcase
        end
      end else if (w_timeout) begin
        r_state     <= S_IDLE;
        r_seq_error <= 1'b1;
        r_cnt       <= '0;
      end else if (w_in_prefix) begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end
    end
  end

  assign bus.key_up      = r_keys[0];
  assign bus.key_down    = r_keys[1];
  assign bus.key_left    = r_keys[2];
  assign bus.key_right   = r_keys[3];
`ifdef PS2_DEC_SPACE_EN
  assign bus.key_space   = r_keys[4];
`endif
  assign bus.make_pulse  = r_make_pulse;
  assign bus.break_pulse = r_break_pulse;
  assign bus.last_code   = r_last_code;
  assign bus.seq_error   = r_seq_error;

endmodule
`default_nettype wire

// File: tb/tb_ps2_arrow_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_arrow_decoder
//  Purpose  : Bench for ps2_arrow_decoder. Two instances share one byte
//             stream: u_r1 with REQUIRE_E0 = 1 and u_r0 with REQUIRE_E0 = 0.
//             Honours PS2_DEC_SPACE_EN when defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ps2_arrow_decoder;

  localparam int T = 16;
`ifdef PS2_DEC_SPACE_EN
  localparam int NK = 5;
`else
  localparam int NK = 4;
`endif
  localparam int W = NK + 11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d   = 8'h00;
  logic       en  = 1'b0;
  logic       chk_en = 1'b0;

  int total = 0;
  int bad   = 0;
  int n_make = 0;

  always #5 clk = ~clk;

  ps2_arrow_decoder_if bus_r1();
  ps2_arrow_decoder_if bus_r0();

  assign bus_r1.received_data    = d;
  assign bus_r1.received_data_en = en;
  assign bus_r0.received_data    = d;
  assign bus_r0.received_data_en = en;

  ps2_arrow_decoder #(.TIMEOUT_CYCLES(T), .REQUIRE_E0(1'b1)) u_r1 (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus_r1)
  );

  ps2_arrow_decoder #(.TIMEOUT_CYCLES(T), .REQUIRE_E0(1'b0)) u_r0 (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus_r0)
  );

  // Observed outputs packed as {keys, make, break, error, last_code}
  logic [W-1:0] act [2];
`ifdef PS2_DEC_SPACE_EN
  assign act[0] = {bus_r1.key_space, bus_r1.key_right, bus_r1.key_left, bus_r1.key_down, bus_r1.key_up,
                   bus_r1.make_pulse, bus_r1.break_pulse, bus_r1.seq_error, bus_r1.last_code};
  assign act[1] = {bus_r0.key_space, bus_r0.key_right, bus_r0.key_left, bus_r0.key_down, bus_r0.key_up,
                   bus_r0.make_pulse, bus_r0.break_pulse, bus_r0.seq_error, bus_r0.last_code};
`else
  assign act[0] = {bus_r1.key_right, bus_r1.key_left, bus_r1.key_down, bus_r1.key_up,
                   bus_r1.make_pulse, bus_r1.break_pulse, bus_r1.seq_error, bus_r1.last_code};
  assign act[1] = {bus_r0.key_right, bus_r0.key_left, bus_r0.key_down, bus_r0.key_up,
                   bus_r0.make_pulse, bus_r0.break_pulse, bus_r0.seq_error, bus_r0.last_code};
`endif

  // ---------------- behavioural model ----------------
  logic [NK-1:0] m_keys [2];
  logic [7:0]    m_last [2];
  logic          m_make [2];
  logic          m_brk  [2];
  logic          m_err  [2];
  logic          p_ext  [2];
  logic          p_brk  [2];
  int            skip   [2];
  int            idle   [2];

  function automatic int key_index(logic [7:0] b, logic ext, int req);
    int k;
    case (b)
      8'h75:   k = 0;
      8'h72:   k = 1;
      8'h6B:   k = 2;
      8'h74:   k = 3;
`ifdef PS2_DEC_SPACE_EN
      8'h29:   k = ext ? -1 : 4;
`endif
      default: k = -1;
    endcase
    if (k >= 0 && k < 4 && req != 0 && !ext) k = -1;
    return k;
  endfunction

  task automatic complete(int i, logic [7:0] b, logic ext, logic brk, int req);
    int k;
    m_last[i] = b;
    p_ext[i]  = 1'b0;
    p_brk[i]  = 1'b0;
    k = key_index(b, ext, req);
    if (k >= 0) begin
      if (!brk) begin
        m_make[i]    = !m_keys[i][k];
        m_keys[i][k] = 1'b1;
      end else begin
        m_brk[i]     = m_keys[i][k];
        m_keys[i][k] = 1'b0;
      end
    end
  endtask

  task automatic step(int i, int req);
    m_make[i] = 1'b0;
    m_brk[i]  = 1'b0;
    m_err[i]  = 1'b0;
    if (rst) begin
      m_keys[i] = '0; m_last[i] = 8'h00;
      p_ext[i] = 1'b0; p_brk[i] = 1'b0; skip[i] = 0; idle[i] = 0;
    end else if (en) begin
      idle[i] = 0;
      if (d == 8'h00 || d == 8'hFF) begin
        m_keys[i] = '0; m_err[i] = 1'b1;
        p_ext[i] = 1'b0; p_brk[i] = 1'b0; skip[i] = 0;
      end else if (skip[i] > 0) begin
        skip[i] = skip[i] - 1;
      end else if (!p_ext[i] && !p_brk[i]) begin
        case (d)
          8'hE0: p_ext[i] = 1'b1;
          8'hF0: p_brk[i] = 1'b1;
          8'hE1: skip[i] = 7;
          8'hAA, 8'hFA, 8'hFE: ;
          default: complete(i, d, 1'b0, 1'b0, req);
        endcase
      end else if (p_brk[i]) begin
        if (!(d == 8'hE0 || d == 8'hF0 || d == 8'hE1)) complete(i, d, p_ext[i], 1'b1, req);
      end else begin
        if (d == 8'hF0) p_brk[i] = 1'b1;
        else if (d != 8'hE0) complete(i, d, 1'b1, 1'b0, req);
      end
    end else if (p_ext[i] || p_brk[i]) begin
      idle[i] = idle[i] + 1;
      if (idle[i] == T) begin
        m_err[i] = 1'b1; p_ext[i] = 1'b0; p_brk[i] = 1'b0; idle[i] = 0;
      end
    end
  endtask

  // Advance the reference model with the inputs the DUTs sample on this edge
  always @(posedge clk) begin
    step(0, 1);
    step(1, 0);
  end

  // Cycle-by-cycle comparison of both instances against the model
  logic [W-1:0] exp_v;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        exp_v = {m_keys[i], m_make[i], m_brk[i], m_err[i], m_last[i]};
        total++;
        if (act[i] !== exp_v) begin
          bad++;
          $display("FAIL outs[%0d] t=%0t got=%h want=%h", i, $time, act[i], exp_v);
        end
      end
      if (bus_r1.make_pulse) n_make++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic send(logic [7:0] b);
    @(posedge clk); #2;
    d = b; en = 1'b1;
    @(posedge clk); #2;
    en = 1'b0;
  endtask

  task automatic wait_cyc(int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  function automatic logic [7:0] pick_byte();
    int r;
    r = $urandom_range(0, 31);
    if (r <= 4) return 8'hE0;
    if (r <= 7) return 8'hF0;
    if (r == 8) return 8'hE1;
    if (r == 13) return 8'h29;
    if (r == 14) return 8'hAA;
    if (r == 15) return 8'hFA;
    if (r == 16) return 8'hFE;
    if (r == 17) return ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
    if (r <= 21) begin
      case ($urandom_range(0, 3))
        0:       return 8'h75;
        1:       return 8'h72;
        2:       return 8'h6B;
        default: return 8'h74;
      endcase
    end
    return 8'($urandom_range(0, 255));
  endfunction

  int mk0;
  int gap;

  initial begin
    // Reset state
    wait_cyc(2);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_r1", 32'(act[0]), 32'h0);
    chk("reset_r0", 32'(act[1]), 32'h0);

    // Extended right arrow make
    send(8'hE0); send(8'h74);
    chk("right_level", 32'(bus_r1.key_right), 32'h1);
    chk("right_make_pulse", 32'(bus_r1.make_pulse), 32'h1);
    chk("right_last_code", 32'(bus_r1.last_code), 32'h74);
    chk("model_pin_right", 32'(m_keys[0][3]), 32'h1);
    wait_cyc(1);
    chk("make_pulse_one_cycle", 32'(bus_r1.make_pulse), 32'h0);

    // Typematic repeat of up, then extended break
    mk0 = n_make;
    repeat (3) begin send(8'hE0); send(8'h75); end
    wait_cyc(1);
    chk("typematic_level", 32'(bus_r1.key_up), 32'h1);
    chk("typematic_single_pulse", 32'(n_make - mk0), 32'h1);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("up_break_level", 32'(bus_r1.key_up), 32'h0);
    chk("up_break_pulse", 32'(bus_r1.break_pulse), 32'h1);
    wait_cyc(1);
    chk("break_pulse_one_cycle", 32'(bus_r1.break_pulse), 32'h0);

    // Overrun while holding keys
    send(8'hE0); send(8'h6B); send(8'hE0); send(8'h75);
    chk("held_before_overrun", 32'(act[0][W-1:11]), 32'hD);
    send(8'hFF);
    chk("overrun_keys", 32'(act[0][W-1:11]), 32'h0);
    chk("overrun_seq_error", 32'(bus_r1.seq_error), 32'h1);
    chk("overrun_no_break", 32'(bus_r1.break_pulse), 32'h0);
    send(8'hE0); send(8'h72);
    chk("down_after_overrun", 32'(act[0][W-1:11]), 32'h2);

    // Pause sequence must not disturb anything
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    chk("pause_keys", 32'(act[0][W-1:11]), 32'h2);
    chk("pause_last_code", 32'(bus_r1.last_code), 32'h72);
    send(8'hE0); send(8'h74);
    chk("right_after_pause", 32'(act[0][W-1:11]), 32'hA);

    // Prefix timeout boundary
    send(8'hE0); send(8'hF0); send(8'h74);
    send(8'hE0);
    wait_cyc(T - 1);
    chk("timeout_not_early", 32'(bus_r1.seq_error), 32'h0);
    wait_cyc(1);
    chk("timeout_seq_error", 32'(bus_r1.seq_error), 32'h1);
    chk("timeout_keys_kept", 32'(act[0][W-1:11]), 32'h2);
    send(8'h74);
    chk("req_e0_right_untracked", 32'(bus_r1.key_right), 32'h0);
    chk("req_e0_last_code", 32'(bus_r1.last_code), 32'h74);
    chk("numpad_right_tracked", 32'(bus_r0.key_right), 32'h1);

    // Byte arriving on the terminal count wins over the timeout
    send(8'hE0);
    wait_cyc(T - 2);
    send(8'h75);
    chk("terminal_byte_no_error", 32'(bus_r1.seq_error), 32'h0);
    chk("terminal_byte_make", 32'(bus_r1.key_up), 32'h1);
    wait_cyc(1);
    chk("terminal_byte_no_late_error", 32'(bus_r1.seq_error), 32'h0);

    // Reset between F0 and the code byte
    send(8'hF0);
    do_reset();
    send(8'h6B);
    chk("reset_mid_seq_make", 32'(bus_r0.key_left), 32'h1);
    chk("reset_mid_seq_pulse", 32'(bus_r0.make_pulse), 32'h1);
    chk("reset_mid_seq_r1_untracked", 32'(bus_r1.key_left), 32'h0);

`ifdef PS2_DEC_SPACE_EN
    send(8'h29);
    chk("space_make", 32'(bus_r1.key_space), 32'h1);
    send(8'hF0); send(8'h29);
    chk("space_break", 32'(bus_r1.key_space), 32'h0);
    chk("space_break_pulse", 32'(bus_r1.break_pulse), 32'h1);
    send(8'hF0);
    do_reset();
    send(8'h29);
    chk("space_reset_mid_make", 32'(bus_r1.key_space), 32'h1);
    chk("space_reset_mid_pulse", 32'(bus_r1.make_pulse), 32'h1);
`endif

    // Randomized traffic checked by the model every cycle
    gap = 0;
    for (int c = 0; c < 6000; c++) begin
      @(posedge clk); #2;
      rst = ($urandom_range(0, 999) == 0);
      if (gap > 0) begin
        en  = 1'b0;
        gap = gap - 1;
      end else begin
        en = 1'b1;
        d  = pick_byte();
        if ($urandom_range(0, 9) == 0) gap = $urandom_range(10, 20);
        else gap = $urandom_range(0, 2);
      end
    end
    @(posedge clk); #2;
    en  = 1'b0;
    rst = 1'b0;
    wait_cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
